// File: rtl/conv_window_gen_pkg.sv
// Shared constants for the 4x4 convolution window path.
package conv_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned KSIZE      = 4;
    localparam int unsigned WIN_ELEMS  = KSIZE * KSIZE;

    // Bit offset of window element (i,j) inside the flattened window bus.
    function automatic int unsigned win_offset(input int unsigned i,
                                               input int unsigned j,
                                               input int unsigned data_w);
        return (i * KSIZE + j) * data_w;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image line of storage: a single address shared by one read and one write.
module conv_line_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Asynchronous read returns the old content in the cycle it is overwritten.
    always_comb begin
        rd_data = mem[addr];
    end

    // Write lands on the clock edge; memory contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 4x4 sliding-window generator feeding the convolution MAC.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_pixel,
    input  logic                        in_sof,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIN_ELEMS*DATA_W-1:0] out_win,
    output logic                        out_frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KSIZE - 1);

    logic [CW-1:0]     col, eff_col;
    logic [RW-1:0]     row, eff_row;
    logic              acc;
    logic              win_hit;
    logic              last_px;
    logic [DATA_W-1:0] lb1_rd, lb2_rd, lb3_rd;
    logic [DATA_W-1:0] new_col [KSIZE];
    logic [DATA_W-1:0] win [KSIZE][KSIZE];

    // Handshake and effective position of the pixel being accepted (sof forces origin).
    always_comb begin
        in_ready = !out_valid || out_ready;
        acc      = in_valid && in_ready;
        eff_col  = in_sof ? '0 : col;
        eff_row  = in_sof ? '0 : row;
        win_hit  = (eff_row >= ROW_FIRST) && (eff_col >= COL_FIRST);
        last_px  = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    end

    // Three chained line stores: each accept pushes the column one line deeper.
    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .we(acc), .addr(eff_col), .wr_data(in_pixel), .rd_data(lb1_rd)
    );
    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
        .clk(clk), .we(acc), .addr(eff_col), .wr_data(lb1_rd), .rd_data(lb2_rd)
    );
    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb3 (
        .clk(clk), .we(acc), .addr(eff_col), .wr_data(lb2_rd), .rd_data(lb3_rd)
    );

    // Incoming column, oldest line on top.
    always_comb begin
        new_col[0] = lb3_rd;
        new_col[1] = lb2_rd;
        new_col[2] = lb1_rd;
        new_col[3] = in_pixel;
    end

    // Raster position of the next pixel, advanced from the effective position.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (eff_col == COL_LAST) begin
                col <= '0;
                row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
            end else begin
                col <= eff_col + CW'(1);
                row <= eff_row;
            end
        end
    end

    // Window register: shift left on every accept, new column enters on the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < KSIZE; i++) begin
                for (int unsigned j = 0; j < KSIZE; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (acc) begin
            for (int unsigned i = 0; i < KSIZE; i++) begin
                for (int unsigned j = 0; j < KSIZE - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][KSIZE-1] <= new_col[i];
            end
        end
    end

    // Output valid/frame-done: a new window wins over consumption of the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_frame_done <= 1'b0;
        end else if (acc && win_hit) begin
            out_valid      <= 1'b1;
            out_frame_done <= last_px;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
            out_frame_done <= 1'b0;
        end
    end

    // Flatten the window onto the MAC operand bus.
    always_comb begin
        out_win = '0;
        for (int unsigned i = 0; i < KSIZE; i++) begin
            for (int unsigned j = 0; j < KSIZE; j++) begin
                out_win[win_offset(i, j, DATA_W) +: DATA_W] = win[i][j];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen with a 6x6 image.
module tb_conv_window_gen;

    localparam int unsigned W = 6;
    localparam int unsigned H = 6;
    localparam logic [127:0] FIRST_WIN = 128'h33323130_23222120_13121110_03020100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_pixel = '0;
    logic         in_sof = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_win;
    logic         out_frame_done;

    conv_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
        .out_frame_done(out_frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;

    typedef struct {
        logic [127:0] win;
        logic         done;
    } exp_t;

    exp_t         q[$];
    logic [7:0]   img [H][W];
    int           m_col = 0, m_row = 0;
    logic [127:0] cap_win[$];
    logic         cap_done[$];

    bit chk_en = 0;
    bit stall_chk = 0;
    bit stall_done = 0;
    int stall_cnt = 0;
    int stall_seen = 0;
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] el(input logic [127:0] w, input int i, input int j);
        return w[(i*4+j)*8 +: 8];
    endfunction

    function automatic int done_count();
        int n = 0;
        foreach (cap_done[k]) if (cap_done[k]) n++;
        return n;
    endfunction

    // Reference model: store pixels by image coordinate, emit windows from the image.
    always @(posedge clk) begin
        bit   m_ready;
        int   r, c;
        exp_t e;
        if (rst) begin
            q.delete();
            m_col = 0;
            m_row = 0;
        end else begin
            m_ready = (q.size() == 0) || out_ready;
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && m_ready) begin
                r = in_sof ? 0 : m_row;
                c = in_sof ? 0 : m_col;
                img[r][c] = in_pixel;
                if (r >= 3 && c >= 3) begin
                    e.win = '0;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            e.win[(i*4+j)*8 +: 8] = img[r-3+i][c-3+j];
                    e.done = (r == H-1) && (c == W-1);
                    q.push_back(e);
                end
                if (c == W-1) begin
                    m_col = 0;
                    m_row = (r == H-1) ? 0 : r + 1;
                end else begin
                    m_col = c + 1;
                    m_row = r;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = q.size() > 0;
            chk("out_valid", {127'd0, out_valid}, {127'd0, ev});
            chk("in_ready", {127'd0, in_ready}, {127'd0, (!ev || out_ready)});
            if (ev) begin
                chk("out_win", out_win, q[0].win);
                chk("frame_done", {127'd0, out_frame_done}, {127'd0, q[0].done});
            end else begin
                chk("frame_done_idle", {127'd0, out_frame_done}, 128'd0);
            end
            if (out_valid && out_ready) begin
                cap_win.push_back(out_win);
                cap_done.push_back(out_frame_done);
            end
            if (stall_chk && out_valid && !out_ready) begin
                stall_seen++;
                chk("stall_win", out_win, FIRST_WIN);
                chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
            end
        end
    end

    // Consumer readiness driver.
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (!stall_done && out_valid && stall_cnt == 0) stall_cnt = 5;
                if (stall_cnt > 0) begin
                    out_ready = 1'b0;
                    stall_cnt--;
                    if (stall_cnt == 0) stall_done = 1;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b1;
        endcase
    end

    task automatic send_px(input logic [7:0] p, input logic s, input bit gaps);
        int  n = 0;
        bit  got;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = s;
        forever begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
            n++;
            if (n > 200) begin
                checks++;
                errs++;
                $display("FAIL accept_timeout: got no in_ready expected in_ready=1 at %0t", $time);
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] base, input int n_px, input bit gaps);
        for (int k = 0; k < n_px; k++) begin
            int r = k / W;
            int c = k % W;
            send_px(base + 8'(r*16 + c), (k == 0), gaps);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errs++;
            $display("FAIL drain_timeout: got pending window expected drained at %0t", $time);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_win", out_win, 128'd0);
        chk("rst_frame_done", {127'd0, out_frame_done}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A: full frame, continuous
        cap_win.delete(); cap_done.delete();
        send_range(8'h00, W*H, 0);
        drain();
        chk("A_count", cap_win.size(), 9);
        chk("A_done_count", done_count(), 1);
        if (cap_win.size() == 9) begin
            chk("A_first_00", el(cap_win[0], 0, 0), 8'h00);
            chk("A_first_03", el(cap_win[0], 0, 3), 8'h03);
            chk("A_first_30", el(cap_win[0], 3, 0), 8'h30);
            chk("A_first_33", el(cap_win[0], 3, 3), 8'h33);
            chk("A_last_00", el(cap_win[8], 0, 0), 8'h22);
            chk("A_last_33", el(cap_win[8], 3, 3), 8'h55);
            chk("A_last_done", {127'd0, cap_done[8]}, 128'd1);
        end

        // B: backpressure at the first window
        cap_win.delete(); cap_done.delete();
        stall_done = 0; stall_seen = 0; stall_chk = 1; rdy_mode = 2;
        send_range(8'h00, W*H, 0);
        drain();
        stall_chk = 0; rdy_mode = 0;
        chk("B_stall_cycles", stall_seen, 5);
        chk("B_count", cap_win.size(), 9);
        foreach (cap_win[k]) begin
            chk("B_order_00", el(cap_win[k], 0, 0), 8'((k/3)*16 + (k%3)));
            chk("B_order_33", el(cap_win[k], 3, 3), 8'((k/3)*16 + (k%3) + 8'h33));
        end

        // C: two frames back-to-back, second offset by 0x80
        cap_win.delete(); cap_done.delete();
        send_range(8'h00, W*H, 0);
        send_range(8'h80, W*H, 0);
        drain();
        chk("C_count", cap_win.size(), 18);
        chk("C_done_count", done_count(), 2);
        if (cap_win.size() == 18) begin
            chk("C_f2_00", el(cap_win[9], 0, 0), 8'h80);
            chk("C_f2_33", el(cap_win[9], 3, 3), 8'hB3);
            for (int k = 0; k < 18; k++)
                for (int e = 0; e < 16; e++)
                    chk("C_no_mix", {127'd0, cap_win[k][e*8+7]}, {127'd0, (k >= 9)});
        end

        // D: reset after pixel 0x24, then a fresh frame
        send_range(8'h00, 17, 0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("D_rst_valid", {127'd0, out_valid}, 128'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("D_post_rst_valid", {127'd0, out_valid}, 128'd0);
        @(posedge clk);
        #1;
        cap_win.delete(); cap_done.delete();
        send_range(8'h00, W*H, 0);
        drain();
        chk("D_count", cap_win.size(), 9);
        chk("D_done_count", done_count(), 1);

        // E: sof reasserted where pixel 0x42 would be, then a full frame
        cap_win.delete(); cap_done.delete();
        send_range(8'h00, 26, 0);
        send_range(8'h00, W*H, 0);
        drain();
        chk("E_count", cap_win.size(), 12);
        chk("E_done_count", done_count(), 1);
        if (cap_win.size() == 12) begin
            chk("E_new_first", cap_win[3], FIRST_WIN);
            chk("E_last_done", {127'd0, cap_done[11]}, 128'd1);
        end

        // F: random input gaps and consumer stalls over three frames
        cap_win.delete(); cap_done.delete();
        rdy_mode = 1;
        send_range(8'h00, W*H, 1);
        send_range(8'h20, W*H, 1);
        send_range(8'hA0, W*H, 1);
        drain();
        rdy_mode = 0;
        chk("F_count", cap_win.size(), 27);
        chk("F_done_count", done_count(), 3);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
